cale_de_control_param: RTL and testbench

- Parametrised successor to the LDH control path: a Moore FSM that qualifies a start pulse and sequences the datapath.
- Sequence: clear the datapath (reset_cd), load operands (load), hold busy for a programmable number of compute cycles, then present ready_s.
- New over the previous generation: configurable compute latency, an ack/auto-ack handshake on ready_s, synchronous abort, and back-to-back restart from DONE.
- Sits between the top-level start/ack interface and the LDH datapath registers.

---
 rtl/cale_de_control_param_if.sv | 24 ++
 rtl/cale_de_control_param.sv | 90 +++++++++
 tb/tb_cale_de_control_param.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cale_de_control_param_if.sv
// Start/ack handshake and datapath-control bundle for cale_de_control_param.
// master = requester/consumer side, slave = the control FSM.
interface cale_de_control_param_if #(
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic             ack;
    logic             abort;
    logic             reset_cd;
    logic             load;
    logic             busy;
    logic             ready_s;
    logic [CNT_W-1:0] cnt;

    modport master (
        output start, ack, abort,
        input  reset_cd, load, busy, ready_s, cnt
    );

    modport slave (
        input  start, ack, abort,
        output reset_cd, load, busy, ready_s, cnt
    );
endinterface

// File: rtl/cale_de_control_param.sv
// Moore control FSM for the LDH datapath: qualifies start, clears, loads, runs for
// LATENCY cycles, then presents ready_s until ack (or automatically with AUTO_ACK).
module cale_de_control_param #(
    parameter int unsigned LATENCY  = 3,
    parameter int unsigned CNT_W    = 4,
    parameter bit          AUTO_ACK = 1'b0
) (
    input logic                    clk,
    input logic                    reset,
    cale_de_control_param_if.slave bus
);

    if (LATENCY < 1 || LATENCY > (64'd1 << CNT_W)) begin : g_bad_latency
        $error("cale_de_control_param: LATENCY must lie in 1..2**CNT_W");
    end

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArmed = 3'd1,
        StLoad  = 3'd2,
        StRun   = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reset_cd_q, load_q, busy_q, ready_s_q;

    always_comb begin
        state_d = StIdle;
        cnt_d   = '0;
        if (bus.abort && state_q != StIdle) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  state_d = bus.start ? StArmed : StIdle;
                StArmed: state_d = bus.start ? StArmed : StLoad;
                StLoad: begin
                    state_d = StRun;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
                StRun: begin
                    if (cnt_q != '0) begin
                        state_d = StRun;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    // Restart beats ack so a waiting requester is never dropped.
                    if (bus.start) begin
                        state_d = StArmed;
                    end else if (bus.ack || AUTO_ACK) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            reset_cd_q <= 1'b0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_s_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reset_cd_q <= (state_d == StArmed);
            load_q     <= (state_d == StLoad);
            busy_q     <= (state_d == StRun);
            ready_s_q  <= (state_d == StDone);
        end
    end

    assign bus.reset_cd = reset_cd_q;
    assign bus.load     = load_q;
    assign bus.busy     = busy_q;
    assign bus.ready_s  = ready_s_q;
    assign bus.cnt      = cnt_q;

endmodule

// File: tb/tb_cale_de_control_param.sv
// Directed bench for cale_de_control_param: three instances cover LATENCY 3/1/8 and
// AUTO_ACK 0/1; each step drives inputs, clocks once, and compares the packed outputs.
module tb_cale_de_control_param;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    cale_de_control_param_if #(.CNT_W(4)) if_a ();
    cale_de_control_param_if #(.CNT_W(4)) if_b ();
    cale_de_control_param_if #(.CNT_W(4)) if_c ();

    cale_de_control_param #(.LATENCY(3), .CNT_W(4), .AUTO_ACK(1'b0)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );
    cale_de_control_param #(.LATENCY(1), .CNT_W(4), .AUTO_ACK(1'b1)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );
    cale_de_control_param #(.LATENCY(8), .CNT_W(4), .AUTO_ACK(1'b0)) u_dut_c (
        .clk   (clk),
        .reset (reset),
        .bus   (if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {reset_cd, load, busy, ready_s, cnt[3:0]}
    localparam logic [7:0] IDL = 8'h00;
    localparam logic [7:0] ARM = 8'h80;
    localparam logic [7:0] LDS = 8'h40;
    localparam logic [7:0] DNS = 8'h10;
    // Packed stimulus: {start, ack, abort}
    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] S1 = 3'b100;
    localparam logic [2:0] AK = 3'b010;
    localparam logic [2:0] AB = 3'b001;
    localparam logic [2:0] SA = 3'b110;

    function automatic logic [7:0] obs(input int sel);
        case (sel)
            0:       obs = {if_a.reset_cd, if_a.load, if_a.busy, if_a.ready_s, if_a.cnt};
            1:       obs = {if_b.reset_cd, if_b.load, if_b.busy, if_b.ready_s, if_b.cnt};
            default: obs = {if_c.reset_cd, if_c.load, if_c.busy, if_c.ready_s, if_c.cnt};
        endcase
    endfunction

    task automatic drive(input int sel, input logic [2:0] in);
        case (sel)
            0: begin if_a.start = in[2]; if_a.ack = in[1]; if_a.abort = in[0]; end
            1: begin if_b.start = in[2]; if_b.ack = in[1]; if_b.abort = in[0]; end
            default: begin if_c.start = in[2]; if_c.ack = in[1]; if_c.abort = in[0]; end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The four control outputs must never overlap.
    always @(negedge clk) begin
        if (reset) begin
            if ($countones({if_a.reset_cd, if_a.load, if_a.busy, if_a.ready_s}) > 1 ||
                $countones({if_b.reset_cd, if_b.load, if_b.busy, if_b.ready_s}) > 1 ||
                $countones({if_c.reset_cd, if_c.load, if_c.busy, if_c.ready_s}) > 1) begin
                miscompares++;
                $display("FAIL onehot at %0t: a=%h b=%h c=%h required at most one hot",
                         $time, obs(0), obs(1), obs(2));
            end
        end
    end

    task automatic test_reset();
        logic [7:0] exp_out;
        reset = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, S0);
        repeat (2) step();
        exp_out = IDL;
        for (int s = 0; s < 3; s++) begin
            vectors++;
            if (obs(s) !== exp_out) begin
                miscompares++;
                $display("FAIL reset dut%0d: got %h required %h", s, obs(s), exp_out);
            end
        end
        reset = 1'b1;
        step();
        vectors++;
        if (obs(0) !== exp_out) begin
            miscompares++;
            $display("FAIL reset_release: got %h required %h", obs(0), exp_out);
        end
    endtask

    task automatic test_basic();
        logic [10:0] v [11];
        v = '{{S1, ARM}, {S1, ARM}, {S1, ARM}, {S0, LDS}, {S0, 8'h22}, {S0, 8'h21},
              {S0, 8'h20}, {S0, DNS}, {S0, DNS}, {AK, IDL}, {S0, IDL}};
        for (int i = 0; i < 11; i++) begin
            drive(0, v[i][10:8]);
            step();
            vectors++;
            if (obs(0) !== v[i][7:0]) begin
                miscompares++;
                $display("FAIL basic step %0d: got %h required %h", i, obs(0), v[i][7:0]);
            end
        end
    endtask

    task automatic test_auto_ack();
        logic [10:0] v [6];
        v = '{{S1, ARM}, {S0, LDS}, {S0, 8'h20}, {S0, DNS}, {S0, IDL}, {S0, IDL}};
        for (int i = 0; i < 6; i++) begin
            drive(1, v[i][10:8]);
            step();
            vectors++;
            if (obs(1) !== v[i][7:0]) begin
                miscompares++;
                $display("FAIL auto_ack step %0d: got %h required %h", i, obs(1), v[i][7:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] v [13];
        v = '{{S1, ARM}, {S0, LDS}, {S0, 8'h22}, {S0, 8'h21}, {S0, 8'h20}, {S0, DNS},
              {SA, ARM}, {S0, LDS}, {S0, 8'h22}, {S0, 8'h21}, {S0, 8'h20}, {S0, DNS},
              {AK, IDL}};
        for (int i = 0; i < 13; i++) begin
            drive(0, v[i][10:8]);
            step();
            vectors++;
            if (obs(0) !== v[i][7:0]) begin
                miscompares++;
                $display("FAIL back_to_back step %0d: got %h required %h", i, obs(0), v[i][7:0]);
            end
        end
        drive(0, S0);
    endtask

    task automatic test_abort();
        logic [10:0] v [21];
        v = '{{S1, ARM}, {S0, LDS}, {S0, 8'h27}, {S0, 8'h26}, {S0, 8'h25}, {AB, IDL},
              {S0, IDL}, {S0, IDL}, {S0, IDL},
              {S1, ARM}, {S0, LDS}, {S0, 8'h27}, {S0, 8'h26}, {S0, 8'h25}, {S0, 8'h24},
              {S0, 8'h23}, {S0, 8'h22}, {S0, 8'h21}, {S0, 8'h20}, {S0, DNS}, {AK, IDL}};
        for (int i = 0; i < 21; i++) begin
            drive(2, v[i][10:8]);
            step();
            vectors++;
            if (obs(2) !== v[i][7:0]) begin
                miscompares++;
                $display("FAIL abort step %0d: got %h required %h", i, obs(2), v[i][7:0]);
            end
        end
        drive(2, S0);
    endtask

    task automatic test_async_reset();
        logic [7:0] exp_run;
        drive(0, S1);
        step();
        drive(0, S0);
        step();
        step();
        exp_run = 8'h22;
        vectors++;
        if (obs(0) !== exp_run) begin
            miscompares++;
            $display("FAIL async_pre: got %h required %h", obs(0), exp_run);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (obs(0) !== IDL) begin
            miscompares++;
            $display("FAIL async_drop: got %h required %h", obs(0), IDL);
        end
        step();
        reset = 1'b1;
        step();
        vectors++;
        if (obs(0) !== IDL) begin
            miscompares++;
            $display("FAIL async_release: got %h required %h", obs(0), IDL);
        end
    endtask

    task automatic test_glitch_run_immunity();
        logic [10:0] v [7];
        v = '{{S1, ARM}, {S0, LDS}, {S1, 8'h22}, {S0, 8'h21}, {S1, 8'h20}, {S0, DNS},
              {AK, IDL}};
        for (int i = 0; i < 7; i++) begin
            drive(0, v[i][10:8]);
            step();
            vectors++;
            if (obs(0) !== v[i][7:0]) begin
                miscompares++;
                $display("FAIL glitch step %0d: got %h required %h", i, obs(0), v[i][7:0]);
            end
        end
        drive(0, S0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_auto_ack();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_glitch_run_immunity();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
